// File: rtl/cmd_reg_arbiter_if.sv
// Write-request bus between the command-register requesters and the arbiter,
// plus the arbiter's status and register-bank outputs.
interface cmd_reg_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int BASE_WORD = 24,
  parameter int NUM_WORDS = 40
);
  logic [NUM_REQ-1:0]      REQ;
  logic [10*NUM_REQ-1:0]   REQ_ADDR;
  logic [16*NUM_REQ-1:0]   REQ_DATA;
  logic [NUM_REQ-1:0]      GNT;
  logic                    BUSY;
  logic                    ERR;
  logic [NUM_WORDS-1:0]    WORD_UPDATED;
  logic [16*(BASE_WORD+NUM_WORDS)-1:16*BASE_WORD] COMMAND_REG;

  modport master (
    output REQ, REQ_ADDR, REQ_DATA,
    input  GNT, BUSY, ERR, WORD_UPDATED, COMMAND_REG
  );

  modport slave (
    input  REQ, REQ_ADDR, REQ_DATA,
    output GNT, BUSY, ERR, WORD_UPDATED, COMMAND_REG
  );
endinterface

// File: rtl/cmd_reg_arbiter.sv
// Round-robin arbiter owning the writable command-register bank: one granted
// requester commits one 16-bit word per two cycles and the changed word is flagged.
module cmd_reg_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BASE_WORD = 24,
  parameter int NUM_WORDS = 40
) (
  input logic SYS_CLK,
  input logic RST_N,
  cmd_reg_arbiter_if.slave bus
);
  localparam int LAST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0] ADDR_LO = 10'(BASE_WORD);
  localparam logic [9:0] ADDR_HI = 10'(BASE_WORD + NUM_WORDS - 1);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t               state_reg;
  logic [LAST_W-1:0]    last_reg;
  logic [9:0]           addr_reg;
  logic [15:0]          data_reg;
  logic [NUM_REQ-1:0]   gnt_reg;
  logic                 busy_reg;
  logic                 err_reg;
  logic [NUM_WORDS-1:0] upd_reg;
  logic [15:0]          bank_reg [NUM_WORDS];

  logic [9:0]  req_addr_arr [NUM_REQ];
  logic [15:0] req_data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_split
      assign req_addr_arr[gi] = bus.REQ_ADDR[10*gi +: 10];
      assign req_data_arr[gi] = bus.REQ_DATA[16*gi +: 16];
    end
  endgenerate

  // Search starts one past the last winner so every requester gets a turn.
  logic                win_valid;
  logic [LAST_W-1:0]   win_idx;
  logic [LAST_W-1:0]   cand;
  logic [NUM_REQ-1:0]  win_onehot;

  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = LAST_W'((int'(last_reg) + off) % NUM_REQ);
      if (!win_valid && bus.REQ[cand]) begin
        win_valid        = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
  end

  logic       in_range;
  logic [9:0] word_idx;
  logic       commit_hit;

  assign in_range   = (addr_reg >= ADDR_LO) && (addr_reg <= ADDR_HI);
  assign word_idx   = addr_reg - ADDR_LO;
  assign commit_hit = (state_reg == COMMIT) && in_range;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      last_reg  <= LAST_W'(NUM_REQ - 1);
      addr_reg  <= '0;
      data_reg  <= '0;
      gnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            addr_reg  <= req_addr_arr[win_idx];
            data_reg  <= req_data_arr[win_idx];
            last_reg  <= win_idx;
            gnt_reg   <= win_onehot;
            busy_reg  <= 1'b1;
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Bank write and status pulses land on the edge that ends COMMIT.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_reg <= 1'b0;
      upd_reg <= '0;
      for (int j = 0; j < NUM_WORDS; j++) begin
        bank_reg[j] <= '0;
      end
    end else begin
      err_reg <= (state_reg == COMMIT) && !in_range;
      for (int j = 0; j < NUM_WORDS; j++) begin
        upd_reg[j] <= commit_hit && (word_idx == 10'(j));
        if (commit_hit && (word_idx == 10'(j))) begin
          bank_reg[j] <= data_reg;
        end
      end
    end
  end

  assign bus.GNT          = gnt_reg;
  assign bus.BUSY         = busy_reg;
  assign bus.ERR          = err_reg;
  assign bus.WORD_UPDATED = upd_reg;

  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_bank_out
      assign bus.COMMAND_REG[16*(BASE_WORD+gi) +: 16] = bank_reg[gi];
    end
  endgenerate
endmodule
